// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides and an iterative shift-add multiplier.
// The multiplier and its CALC state are built only when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b111;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] y_reg, y_next;
    logic [3:0]       flags_reg, flags_next;
    logic             out_valid_reg, out_valid_next;

    // Single-cycle operations
    logic [SW-1:0]    amt;
    logic [WIDTH:0]   add_ext, sub_ext, shl_ext, shr_ext;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c, alu_v;

    assign amt     = b[SW-1:0];
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} - {1'b0, b};
    assign shl_ext = {1'b0, a} << amt;
    assign shr_ext = {a, 1'b0} >> amt;

    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD: begin
                alu_y = add_ext[WIDTH-1:0];
                alu_c = add_ext[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y = sub_ext[WIDTH-1:0];
                alu_c = sub_ext[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_y = a & b;
            OP_OR:  alu_y = a | b;
            OP_XOR: alu_y = a ^ b;
            OP_SHL: begin
                alu_y = shl_ext[WIDTH-1:0];
                alu_c = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_y = shr_ext[WIDTH:1];
                alu_c = shr_ext[0];
            end
            // op 111 lands here when the multiplier is not built: y=0, Z=1
            default: begin
                alu_y = '0;
                alu_c = 1'b0;
            end
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [2*WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0]   mplier_reg, mplier_next;
    logic [SW-1:0]      count_reg, count_next;
    logic [2*WIDTH-1:0] step_acc;

    assign step_acc = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif

    always_comb begin
        state_next     = state_reg;
        y_next         = y_reg;
        flags_next     = flags_reg;
        out_valid_next = out_valid_reg;
`ifdef ALU_SEQ_MUL_EN
        acc_next       = acc_reg;
        mcand_next     = mcand_reg;
        mplier_next    = mplier_reg;
        count_next     = count_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) begin
                        state_next  = CALC;
                        acc_next    = '0;
                        mcand_next  = {{WIDTH{1'b0}}, a};
                        mplier_next = b;
                        count_next  = '0;
                    end else begin
`endif
                        state_next     = DONE;
                        y_next         = alu_y;
                        flags_next     = {alu_y[WIDTH-1], (alu_y == '0), alu_c, alu_v};
                        out_valid_next = 1'b1;
`ifdef ALU_SEQ_MUL_EN
                    end
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            // One multiplier bit per cycle; the last step writes the result directly.
            CALC: begin
                acc_next    = step_acc;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                count_next  = count_reg + SW'(1);
                if (count_reg == SW'(WIDTH - 1)) begin
                    state_next     = DONE;
                    y_next         = step_acc[WIDTH-1:0];
                    flags_next     = {step_acc[WIDTH-1], (step_acc[WIDTH-1:0] == '0),
                                      (step_acc[2*WIDTH-1:WIDTH] != '0), 1'b0};
                    out_valid_next = 1'b1;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b0;
                end
            end
            default: begin
                state_next     = IDLE;
                out_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            y_reg         <= '0;
            flags_reg     <= '0;
            out_valid_reg <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            count_reg     <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            y_reg         <= y_next;
            flags_reg     <= flags_next;
            out_valid_reg <= out_valid_next;
`ifdef ALU_SEQ_MUL_EN
            acc_reg       <= acc_next;
            mcand_reg     <= mcand_next;
            mplier_reg    <= mplier_next;
            count_reg     <= count_next;
`endif
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign y         = y_reg;
    assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): per-cycle comparison against an arithmetic model,
// directed literal cases, backpressure, mid-operation reset and randomized traffic.
module tb_alu_seq;

    localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [3:0]   flags;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result and {N,Z,C,V} from plain integer arithmetic.
    function automatic logic [11:0] model(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
        int ua  = int'(xa);
        int ub  = int'(xb);
        int sa  = int'($signed(xa));
        int sb  = int'($signed(xb));
        int amt = ub % W;
        int r   = 0;
        int c   = 0;
        int v   = 0;
        int yy;
        case (o)
            3'd0: begin r = ua + ub; c = (r > 255) ? 1 : 0; v = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0; end
            3'd1: begin r = ua - ub; c = (ua < ub) ? 1 : 0; v = ((sa - sb) > 127 || (sa - sb) < -128) ? 1 : 0; end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua * (1 << amt); c = (amt > 0) ? ((ua >> (W - amt)) & 1) : 0; end
            3'd6: begin r = ua / (1 << amt); c = (amt > 0) ? ((ua >> (amt - 1)) & 1) : 0; end
            default: begin
                if (MUL_EN) begin r = ua * ub; c = (r > 255) ? 1 : 0; end
                else r = 0;
            end
        endcase
        yy = r & 255;
        return {yy[7:0], (yy >= 128), (yy == 0), c[0], v[0]};
    endfunction

    // Model state advanced once per cycle on the falling edge.
    bit           pending = 1'b0;
    int           rem = 0;
    logic [W-1:0] m_y = '0;
    logic [3:0]   m_f = '0;

    always @(negedge clk) begin
        logic [11:0] r;
        if (rst === 1'b1) begin
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_y", 64'(y), 64'd0);
            check("rst_flags", 64'(flags), 64'd0);
            pending = 1'b0;
        end else if (rst === 1'b0) begin
            check("in_ready", 64'(in_ready), 64'(!pending));
            check("out_valid", 64'(out_valid), 64'(pending && rem == 0));
            if (pending && rem == 0) begin
                check("y", 64'(y), 64'(m_y));
                check("flags", 64'(flags), 64'(m_f));
            end
            if (!pending) begin
                if (in_valid) begin
                    r       = model(op, a, b);
                    m_y     = r[11:4];
                    m_f     = r[3:0];
                    pending = 1'b1;
                    rem     = (op == 3'd7 && MUL_EN) ? W : 0;
                end
            end else if (rem > 0) begin
                rem--;
            end else if (out_ready) begin
                pending = 1'b0;
            end
        end
    end

    task automatic noise();
        in_valid = 1'($urandom);
        op       = 3'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    // Issues one op from IDLE, waits for the result, holds it for 'hold' cycles, then releases it.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb, input int hold,
                          input bit lit_en, input logic [W-1:0] ly, input logic [3:0] lf);
        int lat;
        int exp_lat;
        logic [11:0] mr;
        exp_lat = (o == 3'd7 && MUL_EN) ? W + 1 : 1;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; a = xa; b = xb; out_ready = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        while (!out_valid && lat < 100) begin
            noise();
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_seen", 64'(out_valid), 64'd1);
        if (out_valid) begin
            check("latency", 64'(lat), 64'(exp_lat));
            if (lit_en) begin
                mr = model(o, xa, xb);
                check("lit_y", 64'(y), 64'(ly));
                check("lit_flags", 64'(flags), 64'(lf));
                check("model_pin", 64'(mr), 64'({ly, lf}));
            end
            for (int i = 0; i < hold; i++) begin
                noise();
                @(posedge clk); #1;
            end
            in_valid = 1'b0; out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("ready_after_release", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_op(3'd0, 8'd200, 8'd100, 0, 1'b1, 8'd44, 4'b0010);
        run_op(3'd1, 8'd5, 8'd10, 0, 1'b1, 8'hFB, 4'b1010);
        run_op(3'd1, 8'h80, 8'h01, 0, 1'b1, 8'h7F, 4'b0001);
        run_op(3'd5, 8'h81, 8'd1, 0, 1'b1, 8'h02, 4'b0010);
        run_op(3'd6, 8'h01, 8'd1, 0, 1'b1, 8'h00, 4'b0110);
        run_op(3'd4, 8'hAA, 8'hAA, 0, 1'b1, 8'h00, 4'b0100);
        run_op(3'd5, 8'h81, 8'd0, 0, 1'b1, 8'h81, 4'b1000);
        run_op(3'd0, 8'd1, 8'd2, 5, 1'b1, 8'd3, 4'b0000);
`ifdef ALU_SEQ_MUL_EN
        run_op(3'd7, 8'd13, 8'd11, 0, 1'b1, 8'h8F, 4'b1000);
        run_op(3'd7, 8'd16, 8'd16, 2, 1'b1, 8'h00, 4'b0110);
`else
        run_op(3'd7, 8'd3, 8'd4, 0, 1'b1, 8'h00, 4'b0100);
`endif

        // Reset four cycles into an op 111; nothing from it may surface afterwards.
        @(posedge clk); #1;
        in_valid = 1'b1; op = 3'd7; a = 8'd255; b = 8'd255;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1; in_valid = 1'b1;
        #1;
        check("rst_now_out_valid", 64'(out_valid), 64'd0);
        check("rst_now_y", 64'(y), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_release_ready", 64'(in_ready), 64'd1);
        repeat (12) begin @(posedge clk); #1; end

        for (int i = 0; i < 200; i++)
            run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), $urandom_range(0, 3), 1'b0, '0, '0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
